icache: RTL and testbench
=========================

# icache

Direct-mapped, word-granular instruction cache between the instruction fetch unit and the memory controller. Services fetch requests from its local array on a hit; on a miss it issues a word read (LW encoding) through the controller's icache request port, fills the line and returns the instruction. Read-only: it never writes memory.

## Interface
- INDEX_BITS, 6: log2 of line count (64 lines, one 32-bit word each).
- TAG_BITS, 30-INDEX_BITS: tag width, derived and not overridden.

- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous and active-high.
- rdy_in  input  1  global ready; low freezes all state.
- fetch_valid  input  1  fetch request, held until inst_ready or flush_in.
- fetch_addr  input  32  instruction address; bits [1:0] are ignored.
- flush_in  input  1  cancels any outstanding fetch request (mispredict).
- inst_ready  output  1  one-cycle pulse; inst_out is valid this cycle.
- inst_out  output  32  returned instruction.
- mem_addr  output  32  to controller addr_in_icache.
- mem_data  output  32  to controller data_in_icache; constant 0.
- mem_r_nw  output  1  to controller r_nw_in_icache; constant 1.
- mem_type  output  3  to controller type_in_icache; constant 3'b000 (word).
- mem_activate  output  1  to controller activate_in_icache.
- mem_data_in  input  32  controller data_out.
- mem_data_available  input  1  controller data_available.
- mem_block  input  1  controller icache_block; high means the LSB owns the port or the current response.

## Operation
- Index = fetch_addr[INDEX_BITS+1:2]; tag = fetch_addr[31:INDEX_BITS+2]. Each line holds a valid bit, a tag and a data word.
- States: IDLE, MISS and RESP. With ICACHE_PREFETCH_EN defined, a PREFETCH state is added.
- IDLE, with fetch_valid high and flush_in low:
  - Hit: latch the data into inst_out, pulse inst_ready next cycle, stay in IDLE.
  - Miss: latch the address, set mem_addr to {addr[31:2],2'b00}, go to MISS.
- MISS: mem_activate=1. A response belongs to the icache only when mem_data_available=1 and mem_block=0. On an owned response:
  - Write the array: valid=1, tag, data = mem_data_in.
  - Go to RESP.
  - Drop mem_activate from the next cycle.
- RESP: pulse inst_ready with inst_out = the filled word, unless the request was cancelled; then go to IDLE.
- flush_in in IDLE discards the request. In MISS the memory read is not aborted: it completes, the line is filled, and the inst_ready pulse is suppressed (a cancel flag, cleared on the return to IDLE).
- flush_in together with a new fetch_valid in the same cycle: flush wins and the request is ignored that cycle.
- Responses with mem_block=1 are ignored. mem_activate stays high until an owned response arrives.
- After inst_ready, the fetch unit may present a new address in the next cycle.

## Timing
- Reset values: inst_ready=0, inst_out=0, mem_activate=0, mem_addr=0, all valid bits 0, state IDLE. Asserting rst_in mid-miss returns to IDLE immediately; any later controller response is ignored.
- Hit latency: request sampled at edge N, inst_ready high in cycle N+1.
- Miss latency with an uncontended controller: mem_activate rises in N+1, the controller accepts in N+1, data_available in N+5, array written at the end of N+5, inst_ready in N+6.
- Each cycle of LSB contention (mem_block high) adds one cycle.
- rdy_in=0: no state change and outputs hold; inst_ready keeps its value but must not be treated as consumed.

## Configuration
- ICACHE_PREFETCH_EN defined:
  - After a RESP for address A, if line A+4 is invalid or its tag mismatches, enter PREFETCH with mem_addr=A+4, fill that line on the owned response, then return to IDLE.
  - A fetch that arrives during PREFETCH waits until the prefetch completes, then is looked up normally; a fetch of A+4 therefore hits.
  - flush_in does not abort a prefetch.
- Undefined: no PREFETCH state. Behaviour is exactly the base operation above.

## Structure
- The shared package holds:
  - memory type encodings (LW 3'b000, LHU 3'b001, LBU 3'b010, LH 3'b101, LB 3'b110), also used by the LSB and memory controller;
  - the icache state enum;
  - the INDEX_BITS default.
- Sub-module icache_array: valid/tag/data storage with a combinational read port (index to valid, tag, data) and a synchronous write port. Valid bits are asynchronously cleared by rst_in.

## Test plan
- Cold miss on 0x00000000 with memory word 0x00500093: mem_activate asserted, mem_addr=0, inst_out=0x00500093 after 6 cycles; a repeat fetch hits with inst_ready 1 cycle after the request.
- Aliasing: fetch 0x00000000, then 0x00000100 (same index, INDEX_BITS=6); the second fetch misses and replaces the line; refetching 0x00000000 misses again.
- LSB contention: during MISS, the controller returns an LSB response (mem_data_available=1, mem_block=1) with data 0xDEADBEEF; the icache ignores it, stays in MISS, and returns the correct word later.
- flush_in two cycles into a miss: no inst_ready; the line is still filled, so a later fetch of the same address hits.
- Asynchronous rst_in mid-miss: mem_activate and inst_ready drop to 0 without waiting for a clock edge, and all lines become invalid.
- ICACHE_PREFETCH_EN: a miss on 0x1000 causes a read of 0x1004; a subsequent fetch of 0x1004 hits with 1-cycle latency.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: definitions shared by the instruction cache, the LSB and the
// memory controller.
//   - MEM_* : memory access type encodings driven on the controller type port
//   - icache_state_e : instruction cache controller states
//   - ICACHE_INDEX_BITS : default log2 line count
// Optional build macro: ICACHE_PREFETCH_EN adds the ST_PREFETCH state.
package icache_pkg;

  localparam int ICACHE_INDEX_BITS = 6;

  localparam logic [2:0] MEM_LW  = 3'b000;
  localparam logic [2:0] MEM_LHU = 3'b001;
  localparam logic [2:0] MEM_LBU = 3'b010;
  localparam logic [2:0] MEM_LH  = 3'b101;
  localparam logic [2:0] MEM_LB  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MISS     = 2'd1,
`ifdef ICACHE_PREFETCH_EN
    ST_PREFETCH = 2'd3,
`endif
    ST_RESP     = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// icache_array: line storage for the direct-mapped instruction cache.
// One valid bit, one tag and one 32-bit word per line.
// Ports:
//   clk_in, rst_in        clock; asynchronous active-high reset (valid bits only)
//   rd_index              combinational read index
//   rd_valid/rd_tag/rd_data  contents of line rd_index
//   wr_en/wr_index/wr_tag/wr_data  synchronous line fill; sets the valid bit
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);
  localparam int LINES = 1 << INDEX_BITS;

  logic                valid_reg [LINES];
  logic [TAG_BITS-1:0] tag_mem   [LINES];
  logic [31:0]         data_mem  [LINES];

  // Only the valid bits need resetting; tag and data are don't-care while
  // the line is invalid, so they stay plain (reset-free) storage.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_index == INDEX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line, read-only instruction cache
// between the fetch unit and the memory controller's icache port.
// Ports:
//   clk_in, rst_in, rdy_in         clock, async active-high reset, global ready
//   fetch_valid, fetch_addr        fetch request (held until inst_ready/flush_in)
//   flush_in                       cancels the outstanding fetch
//   inst_ready, inst_out           one-cycle result pulse and instruction
//   mem_addr/mem_data/mem_r_nw/mem_type/mem_activate  controller request
//   mem_data_in/mem_data_available/mem_block          controller response
// Optional build macro: ICACHE_PREFETCH_EN fetches the next sequential word
// into the cache after every miss when that line is not already present.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic        flush_in,
  output logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_r_nw,
  output logic [2:0]  mem_type,
  output logic        mem_activate,
  input  logic [31:0] mem_data_in,
  input  logic        mem_data_available,
  input  logic        mem_block
);
  localparam int TAG_BITS = 30 - INDEX_BITS;

  icache_state_e state_reg, state_next;

  logic [29:0] miss_word_reg;  // word address of the line being filled
  logic        cancel_reg;     // outstanding miss was flushed: fill, no pulse
  logic        inst_ready_reg;
  logic [31:0] inst_out_reg;
  logic [31:0] mem_addr_reg;

  logic [INDEX_BITS-1:0] rd_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [31:0]           rd_data;
  logic                  hit;
  logic                  accept;
  logic                  owned_rsp;
  logic                  fill_en;

  // Byte offset within the word is irrelevant to an instruction fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^fetch_addr[1:0];

`ifdef ICACHE_PREFETCH_EN
  logic [29:0] next_word;
  assign next_word = miss_word_reg + 30'd1;
`endif

  // The single read port looks up the fetch address, except in RESP where it
  // probes the sequential successor to decide whether to prefetch.
  always_comb begin
    rd_index   = fetch_addr[INDEX_BITS+1:2];
    lookup_tag = fetch_addr[31:INDEX_BITS+2];
`ifdef ICACHE_PREFETCH_EN
    if (state_reg == ST_RESP) begin
      rd_index   = next_word[INDEX_BITS-1:0];
      lookup_tag = next_word[29:INDEX_BITS];
    end
`endif
  end

  assign hit       = rd_valid && (rd_tag == lookup_tag);
  // While inst_ready is high the fetch unit is still holding the request it
  // just got answered; accepting it again would answer it twice.
  assign accept    = (state_reg == ST_IDLE) && fetch_valid && !flush_in && !inst_ready_reg;
  // A response is ours only when the LSB is not using the port.
  assign owned_rsp = mem_data_available && !mem_block;
  assign fill_en   = rdy_in && mem_activate && owned_rsp;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_index (miss_word_reg[INDEX_BITS-1:0]),
    .wr_tag   (miss_word_reg[29:INDEX_BITS]),
    .wr_data  (mem_data_in)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= ST_IDLE;
    end else if (rdy_in) begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !hit) begin
          state_next = ST_MISS;
        end
      end
      ST_MISS: begin
        if (owned_rsp) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
`ifdef ICACHE_PREFETCH_EN
        state_next = hit ? ST_IDLE : ST_PREFETCH;
`else
        state_next = ST_IDLE;
`endif
      end
`ifdef ICACHE_PREFETCH_EN
      ST_PREFETCH: begin
        if (owned_rsp) begin
          state_next = ST_IDLE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    mem_activate = 1'b0;
    case (state_reg)
      ST_MISS:     mem_activate = 1'b1;
`ifdef ICACHE_PREFETCH_EN
      ST_PREFETCH: mem_activate = 1'b1;
`endif
      default:     mem_activate = 1'b0;
    endcase
  end

  // Result and request registers. inst_ready is raised on the edge that
  // completes the lookup or fill, so it is high during the following cycle
  // (IDLE after a hit, RESP after a miss).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inst_ready_reg <= 1'b0;
      inst_out_reg   <= '0;
      mem_addr_reg   <= '0;
      miss_word_reg  <= '0;
      cancel_reg     <= 1'b0;
    end else if (rdy_in) begin
      inst_ready_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (hit) begin
              inst_ready_reg <= 1'b1;
              inst_out_reg   <= rd_data;
            end else begin
              miss_word_reg <= fetch_addr[31:2];
              mem_addr_reg  <= {fetch_addr[31:2], 2'b00};
            end
          end
        end
        ST_MISS: begin
          if (flush_in) begin
            cancel_reg <= 1'b1;
          end
          if (owned_rsp && !cancel_reg && !flush_in) begin
            inst_ready_reg <= 1'b1;
            inst_out_reg   <= mem_data_in;
          end
        end
        ST_RESP: begin
          cancel_reg <= 1'b0;
`ifdef ICACHE_PREFETCH_EN
          if (!hit) begin
            miss_word_reg <= next_word;
            mem_addr_reg  <= {next_word, 2'b00};
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign inst_ready = inst_ready_reg;
  assign inst_out   = inst_out_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_data   = 32'd0;
  assign mem_r_nw   = 1'b1;
  assign mem_type   = MEM_LW;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a behavioural memory controller (fixed
// latency, optional LSB responses stealing the port) plus a line-presence
// model of the cache used to predict hit/miss, latency and data.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        flush_in;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_r_nw;
  logic [2:0]  mem_type;
  logic        mem_activate;
  logic [31:0] mem_data_in;
  logic        mem_data_available;
  logic        mem_block;

  int checks = 0;
  int errors = 0;
  int lsb_k  = 0;          // LSB responses inserted ahead of each icache response
  logic [31:0] rd_log[$];  // addresses the controller was asked to read

  bit          m_valid [64];
  logic [23:0] m_tag   [64];

  always #5 clk_in = ~clk_in;

  icache dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .fetch_valid        (fetch_valid),
    .fetch_addr         (fetch_addr),
    .flush_in           (flush_in),
    .inst_ready         (inst_ready),
    .inst_out           (inst_out),
    .mem_addr           (mem_addr),
    .mem_data           (mem_data),
    .mem_r_nw           (mem_r_nw),
    .mem_type           (mem_type),
    .mem_activate       (mem_activate),
    .mem_data_in        (mem_data_in),
    .mem_data_available (mem_data_available),
    .mem_block          (mem_block)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  function automatic bit model_has(input logic [31:0] a);
    return m_valid[a[7:2]] && (m_tag[a[7:2]] == a[31:8]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_valid[a[7:2]] = 1'b1;
    m_tag[a[7:2]]   = a[31:8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Predict hit/miss for a fetch and update line presence afterwards.
  task automatic model_access(input logic [31:0] a, output bit h);
    h = model_has(a);
    if (!h) begin
      model_fill(a);
`ifdef ICACHE_PREFETCH_EN
      begin
        logic [31:0] nxt;
        nxt = {a[31:2] + 30'd1, 2'b00};
        if (!model_has(nxt)) model_fill(nxt);
      end
`endif
    end
  endtask

  // Memory controller: accepts in the first cycle mem_activate is seen,
  // answers 4 cycles later, after lsb_k cycles of LSB-owned responses.
  initial begin
    logic [31:0] a;
    int k;
    mem_data_available = 1'b0;
    mem_block          = 1'b0;
    mem_data_in        = '0;
    forever begin
      @(negedge clk_in);
      if (mem_activate === 1'b1 && rst_in === 1'b0) begin
        a = mem_addr;
        k = lsb_k;
        rd_log.push_back(a);
        repeat (4) @(posedge clk_in);
        #1;
        for (int i = 0; i < k; i++) begin
          mem_data_available = 1'b1;
          mem_block          = 1'b1;
          mem_data_in        = 32'hDEADBEEF;
          @(posedge clk_in);
          #1;
        end
        mem_data_available = 1'b1;
        mem_block          = 1'b0;
        mem_data_in        = mem_word(a);
        @(posedge clk_in);
        #1;
        mem_data_available = 1'b0;
        mem_block          = 1'b0;
        mem_data_in        = '0;
      end
    end
  end

  // One fetch: returns cycles from the sampling edge to inst_ready (-1 on
  // timeout), the returned word and the first mem_addr seen with mem_activate.
  task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] d,
                          output bit act_seen, output logic [31:0] act_addr);
    lat = -1; d = '0; act_seen = 1'b0; act_addr = '0;
    @(posedge clk_in); #1;
    fetch_valid = 1'b1;
    fetch_addr  = a;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (mem_activate === 1'b1 && !act_seen) begin
        act_seen = 1'b1;
        act_addr = mem_addr;
      end
      if (inst_ready === 1'b1) begin
        lat = c;
        d   = inst_out;
        break;
      end
    end
    fetch_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (16) @(posedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; flush_in = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (inst_ready !== 1'b0 || inst_out !== 32'd0 || mem_activate !== 1'b0 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b out=%h act=%b addr=%h expected 0/0/0/0",
               inst_ready, inst_out, mem_activate, mem_addr);
    end
    checks++;
    if (mem_data !== 32'd0 || mem_r_nw !== 1'b1 || mem_type !== icache_pkg::MEM_LW) begin
      errors++;
      $display("FAIL reset_constants: got data=%h r_nw=%b type=%b expected 0/1/000",
               mem_data, mem_r_nw, mem_type);
    end
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    $display("test_reset done");
  endtask

  task automatic test_cold_miss();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h;
    lsb_k = 0;
    model_access(32'h0, h);
    do_fetch(32'h0, lat, d, s, sa);
    checks++;
    if (s !== 1'b1 || sa !== 32'h0) begin
      errors++; $display("FAIL cold_miss_request: got act=%b addr=%h expected 1/00000000", s, sa);
    end
    checks++;
    if (lat != 6 || d !== 32'h00500093) begin
      errors++; $display("FAIL cold_miss_result: got lat=%0d data=%h expected 6/00500093", lat, d);
    end
    settle();
    model_access(32'h0, h);
    do_fetch(32'h0, lat, d, s, sa);
    checks++;
    if (lat != 1 || d !== 32'h00500093 || s !== 1'b0) begin
      errors++; $display("FAIL cold_refetch_hit: got lat=%0d data=%h act=%b expected 1/00500093/0", lat, d, s);
    end
    $display("test_cold_miss: lat=%0d data=%h", lat, d);
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [31:0] d1, d2; bit s; logic [31:0] sa; bit h;
    model_access(32'h4, h);
    do_fetch(32'h4, lat1, d1, s, sa);
    settle();
    model_access(32'h0, h);
    model_access(32'h4, h);
    do_fetch(32'h0, lat1, d1, s, sa);
    do_fetch(32'h4, lat2, d2, s, sa);
    checks++;
    if (lat1 != 1 || lat2 != 1 || d1 !== mem_word(32'h0) || d2 !== mem_word(32'h4)) begin
      errors++;
      $display("FAIL back_to_back: got lat=%0d/%0d data=%h/%h expected 1/1 %h/%h",
               lat1, lat2, d1, d2, mem_word(32'h0), mem_word(32'h4));
    end
    $display("test_back_to_back: lat=%0d/%0d", lat1, lat2);
  endtask

  task automatic test_aliasing();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h;
    logic [31:0] seq [3];
    seq[0] = 32'h0; seq[1] = 32'h100; seq[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      model_access(seq[i], h);
      do_fetch(seq[i], lat, d, s, sa);
      checks++;
      if (lat != (h ? 1 : 6) || d !== mem_word(seq[i]) || (i > 0 && h)) begin
        errors++;
        $display("FAIL aliasing_%0d: got lat=%0d data=%h expected lat=%0d data=%h (miss)",
                 i, lat, d, h ? 1 : 6, mem_word(seq[i]));
      end
      $display("test_aliasing: addr=%h lat=%0d", seq[i], lat);
      settle();
    end
  endtask

  task automatic test_contention();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h;
    lsb_k = 3;
    model_access(32'h2010, h);
    do_fetch(32'h2010, lat, d, s, sa);
    checks++;
    if (lat != 9 || d !== mem_word(32'h2010)) begin
      errors++;
      $display("FAIL contention: got lat=%0d data=%h expected 9/%h", lat, d, mem_word(32'h2010));
    end
    settle();
    lsb_k = 0;
    $display("test_contention: lat=%0d data=%h", lat, d);
  endtask

  task automatic test_flush_miss();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h; bit pulsed;
    model_access(32'h3040, h);
    @(posedge clk_in); #1;
    fetch_valid = 1'b1; fetch_addr = 32'h3040;
    repeat (3) @(posedge clk_in);
    #1;
    flush_in = 1'b1; fetch_valid = 1'b0;
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    pulsed = 1'b0;
    repeat (16) begin
      @(negedge clk_in);
      if (inst_ready !== 1'b0) pulsed = 1'b1;
    end
    checks++;
    if (pulsed !== 1'b0) begin
      errors++; $display("FAIL flush_miss_no_pulse: got inst_ready pulse=%b expected 0", pulsed);
    end
    do_fetch(32'h3040, lat, d, s, sa);
    checks++;
    if (lat != 1 || d !== mem_word(32'h3040)) begin
      errors++;
      $display("FAIL flush_miss_filled: got lat=%0d data=%h expected 1/%h", lat, d, mem_word(32'h3040));
    end
    $display("test_flush_miss: refetch lat=%0d", lat);
  endtask

  task automatic test_flush_same_cycle();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h; bit busy;
    @(posedge clk_in); #1;
    fetch_valid = 1'b1; flush_in = 1'b1; fetch_addr = 32'h4000;
    @(posedge clk_in); #1;
    fetch_valid = 1'b0; flush_in = 1'b0;
    busy = 1'b0;
    repeat (8) begin
      @(negedge clk_in);
      if (mem_activate !== 1'b0 || inst_ready !== 1'b0) busy = 1'b1;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_same_cycle: got activity=%b expected 0", busy);
    end
    model_access(32'h4000, h);
    do_fetch(32'h4000, lat, d, s, sa);
    checks++;
    if (lat != 6 || d !== mem_word(32'h4000)) begin
      errors++;
      $display("FAIL flush_same_cycle_later_miss: got lat=%0d data=%h expected 6/%h", lat, d, mem_word(32'h4000));
    end
    settle();
    $display("test_flush_same_cycle: later lat=%0d", lat);
  endtask

  task automatic test_rdy_freeze();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h;
    model_access(32'h0, h);
    do_fetch(32'h0, lat, d, s, sa);
    settle();
    model_access(32'h0, h);
    @(posedge clk_in); #1;
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checks++;
      if (inst_ready !== 1'b1 || inst_out !== mem_word(32'h0)) begin
        errors++;
        $display("FAIL rdy_freeze_hold_%0d: got rdy=%b out=%h expected 1/%h", i, inst_ready, inst_out, mem_word(32'h0));
      end
      @(posedge clk_in);
    end
    #1;
    rdy_in = 1'b1; fetch_valid = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if (inst_ready !== 1'b0) begin
      errors++; $display("FAIL rdy_freeze_release: got inst_ready=%b expected 0", inst_ready);
    end
    settle();
    $display("test_rdy_freeze done");
  endtask

`ifdef ICACHE_PREFETCH_EN
  task automatic test_prefetch();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h; bit found;
    rd_log.delete();
    model_access(32'h1000, h);
    do_fetch(32'h1000, lat, d, s, sa);
    checks++;
    if (lat != 6 || d !== mem_word(32'h1000)) begin
      errors++; $display("FAIL prefetch_miss: got lat=%0d data=%h expected 6/%h", lat, d, mem_word(32'h1000));
    end
    settle();
    found = 1'b0;
    foreach (rd_log[i]) if (rd_log[i] == 32'h1004) found = 1'b1;
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL prefetch_read: got read of 00001004=%b expected 1", found);
    end
    model_access(32'h1004, h);
    do_fetch(32'h1004, lat, d, s, sa);
    checks++;
    if (lat != 1 || d !== mem_word(32'h1004)) begin
      errors++; $display("FAIL prefetch_hit: got lat=%0d data=%h expected 1/%h", lat, d, mem_word(32'h1004));
    end
    $display("test_prefetch: next-line lat=%0d", lat);
  endtask
`endif

  task automatic test_random();
    int lat, exp_lat; logic [31:0] d, a, exp_d; bit s; logic [31:0] sa; bit h;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      lsb_k = $urandom_range(0, 2);
      model_access(a, h);
      exp_lat = h ? 1 : 6 + lsb_k;
      exp_d   = mem_word({a[31:2], 2'b00});
      do_fetch(a, lat, d, s, sa);
      checks++;
      if (lat != exp_lat || d !== exp_d || s !== !h || (!h && sa !== {a[31:2], 2'b00})) begin
        errors++;
        $display("FAIL random_%0d: addr=%h got lat=%0d data=%h act=%b maddr=%h expected lat=%0d data=%h act=%b",
                 n, a, lat, d, s, sa, exp_lat, exp_d, !h);
      end
      $display("random %0d: addr=%h hit=%0d lat=%0d data=%h", n, a, h, lat, d);
      if (!h) settle();
    end
    lsb_k = 0;
  endtask

  task automatic test_reset_mid_miss();
    int lat; logic [31:0] d; bit s; logic [31:0] sa; bit h;
    @(posedge clk_in); #1;
    fetch_valid = 1'b1; fetch_addr = 32'h5080;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (mem_activate !== 1'b1) begin
      errors++; $display("FAIL reset_mid_miss_active: got mem_activate=%b expected 1", mem_activate);
    end
    #3;
    rst_in = 1'b1; fetch_valid = 1'b0;
    #1;
    checks++;
    if (mem_activate !== 1'b0 || inst_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_miss_async: got act=%b rdy=%b expected 0/0", mem_activate, inst_ready);
    end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_clear();
    settle();
    model_access(32'h5080, h);
    do_fetch(32'h5080, lat, d, s, sa);
    checks++;
    if (lat != 6 || d !== mem_word(32'h5080)) begin
      errors++; $display("FAIL reset_stale_rsp_ignored: got lat=%0d data=%h expected 6/%h", lat, d, mem_word(32'h5080));
    end
    settle();
    model_access(32'h0, h);
    do_fetch(32'h0, lat, d, s, sa);
    checks++;
    if (lat != 6 || d !== 32'h00500093) begin
      errors++; $display("FAIL reset_lines_invalid: got lat=%0d data=%h expected 6/00500093", lat, d);
    end
    settle();
    $display("test_reset_mid_miss done");
  endtask

  initial begin
    rst_in = 1'b1;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_aliasing();
    test_contention();
    test_flush_miss();
    test_flush_same_cycle();
    test_rdy_freeze();
`ifdef ICACHE_PREFETCH_EN
    test_prefetch();
`endif
    test_random();
    test_reset_mid_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
